// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational 32-bit ALU between two
// requesters. Round-robin grant into a registered EXEC stage that drives the
// ALU, then the ALU result is captured into the owner's response buffer.
//
// Handshake semantics (all ports): a transfer happens on a rising edge where
// valid and ready are both high. Request ready is combinational from req
// valid, registered busy and the rr pointer only. Response valid is a
// registered level that stays high with stable data until rsp_ready is seen.
module alu_share_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_c,
    output logic        rsp0_zf,
    output logic        rsp0_of,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_c,
    output logic        rsp1_zf,
    output logic        rsp1_of,
    output logic        rsp1_err,
    output logic [2:0]  alu_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_c,
    input  logic        alu_zf,
    input  logic        alu_of
);

    logic [1:0]  r_busy;
    logic        r_rr;
    logic        r_exec_valid;
    logic        r_exec_id;
    logic        r_exec_ill;
    logic [2:0]  r_alu_ctrl;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;

    logic        r_rsp0_valid;
    logic [31:0] r_rsp0_c;
    logic        r_rsp0_zf;
    logic        r_rsp0_of;
    logic        r_rsp0_err;
    logic        r_rsp1_valid;
    logic [31:0] r_rsp1_c;
    logic        r_rsp1_zf;
    logic        r_rsp1_of;
    logic        r_rsp1_err;

    logic        w_elig0;
    logic        w_elig1;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_ill0;
    logic        w_ill1;
    logic        w_hs0;
    logic        w_hs1;

    // Eligibility, round-robin grant and illegal-op decode; reset masks grants.
    always_comb begin
        w_elig0  = req0_valid & ~r_busy[0];
        w_elig1  = req1_valid & ~r_busy[1];
        w_grant0 = ~rst & w_elig0 & (~w_elig1 | ~r_rr);
        w_grant1 = ~rst & w_elig1 & (~w_elig0 |  r_rr);
        w_ill0   = (req0_op == 3'b010) | (req0_op == 3'b111);
        w_ill1   = (req1_op == 3'b010) | (req1_op == 3'b111);
        w_hs0    = r_rsp0_valid & rsp0_ready;
        w_hs1    = r_rsp1_valid & rsp1_ready;
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // EXEC stage: load ALU operands of the granted request and advance rr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr         <= 1'b0;
            r_exec_valid <= 1'b0;
            r_exec_id    <= 1'b0;
            r_exec_ill   <= 1'b0;
            r_alu_ctrl   <= 3'b000;
            r_alu_a      <= 32'd0;
            r_alu_b      <= 32'd0;
        end else begin
            r_exec_valid <= w_grant0 | w_grant1;
            if (w_grant0) begin
                r_alu_ctrl <= req0_op;
                r_alu_a    <= req0_a;
                r_alu_b    <= req0_b;
                r_exec_id  <= 1'b0;
                r_exec_ill <= w_ill0;
                r_rr       <= 1'b1;
            end else if (w_grant1) begin
                r_alu_ctrl <= req1_op;
                r_alu_a    <= req1_a;
                r_alu_b    <= req1_b;
                r_exec_id  <= 1'b1;
                r_exec_ill <= w_ill1;
                r_rr       <= 1'b0;
            end
        end
    end

    // Busy flags: set on accept, cleared on the response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 2'b00;
        end else begin
            if (w_grant0)   r_busy[0] <= 1'b1;
            else if (w_hs0) r_busy[0] <= 1'b0;
            if (w_grant1)   r_busy[1] <= 1'b1;
            else if (w_hs1) r_busy[1] <= 1'b0;
        end
    end

    // Requester 0 response buffer: capture ALU output, hold until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_c     <= 32'd0;
            r_rsp0_zf    <= 1'b0;
            r_rsp0_of    <= 1'b0;
            r_rsp0_err   <= 1'b0;
        end else if (r_exec_valid && !r_exec_id) begin
            r_rsp0_valid <= 1'b1;
            r_rsp0_c     <= r_exec_ill ? 32'd0 : alu_c;
            r_rsp0_zf    <= ~r_exec_ill & alu_zf;
            r_rsp0_of    <= ~r_exec_ill & alu_of;
            r_rsp0_err   <= r_exec_ill;
        end else if (w_hs0) begin
            r_rsp0_valid <= 1'b0;
        end
    end

    // Requester 1 response buffer: capture ALU output, hold until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp1_valid <= 1'b0;
            r_rsp1_c     <= 32'd0;
            r_rsp1_zf    <= 1'b0;
            r_rsp1_of    <= 1'b0;
            r_rsp1_err   <= 1'b0;
        end else if (r_exec_valid && r_exec_id) begin
            r_rsp1_valid <= 1'b1;
            r_rsp1_c     <= r_exec_ill ? 32'd0 : alu_c;
            r_rsp1_zf    <= ~r_exec_ill & alu_zf;
            r_rsp1_of    <= ~r_exec_ill & alu_of;
            r_rsp1_err   <= r_exec_ill;
        end else if (w_hs1) begin
            r_rsp1_valid <= 1'b0;
        end
    end

    assign alu_ctrl   = r_alu_ctrl;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_c     = r_rsp0_c;
    assign rsp0_zf    = r_rsp0_zf;
    assign rsp0_of    = r_rsp0_of;
    assign rsp0_err   = r_rsp0_err;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_c     = r_rsp1_c;
    assign rsp1_zf    = r_rsp1_zf;
    assign rsp1_of    = r_rsp1_of;
    assign rsp1_err   = r_rsp1_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU on the alu_* port, a
// transaction-level model of two requesters (outstanding op, accept cycle,
// expected result queue) and a last-grant pointer, checked every cycle.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_c, rsp1_c;
  logic        rsp0_zf, rsp0_of, rsp0_err, rsp1_zf, rsp1_of, rsp1_err;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_c;
  logic        alu_zf, alu_of;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c),
    .rsp0_zf(rsp0_zf), .rsp0_of(rsp0_of), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c),
    .rsp1_zf(rsp1_zf), .rsp1_of(rsp1_of), .rsp1_err(rsp1_err),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c(alu_c), .alu_zf(alu_zf), .alu_of(alu_of)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural ALU: {of, zf, c} ----------------
  function automatic logic [33:0] alu_fn(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] c;
    logic        of;
    of = 1'b0;
    case (op)
      3'b000: c = a & b;
      3'b001: c = a | b;
      3'b011: c = (a < b) ? 32'd1 : 32'd0;
      3'b100: begin c = a + b; of = (a[31] == b[31]) && (c[31] != a[31]); end
      3'b101: c = a + b;
      3'b110: begin c = a - b; of = (a[31] != b[31]) && (c[31] != a[31]); end
      default: return {1'b1, 1'b1, 32'hDEADBEEF};
    endcase
    return {of, (c == 32'd0), c};
  endfunction

  logic [33:0] alu_out;
  assign alu_out = alu_fn(alu_ctrl, alu_a, alu_b);
  assign alu_c   = alu_out[31:0];
  assign alu_zf  = alu_out[32];
  assign alu_of  = alu_out[33];

  // Expected response word {err, of, zf, c}
  function automatic logic [34:0] ref_rsp(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (op == 3'b010 || op == 3'b111) return {1'b1, 34'd0};
    return {1'b0, alu_fn(op, a, b)};
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  logic [34:0] exp_q0[$];
  logic [34:0] exp_q1[$];
  bit          out_v[2];
  int          acc_cyc[2];
  bit          last_grant1;   // 1: last grant went to requester 0 so 1 has priority
  logic [2:0]  last_op;
  logic [31:0] last_a, last_b;

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    out_v[0] = 0; out_v[1] = 0;
    last_grant1 = 0;
    last_op = 3'd0; last_a = 32'd0; last_b = 32'd0;
  endtask

  // Per-cycle check of all outputs against the model, then model update for
  // the transfers that the coming rising edge will perform.
  task automatic check_cycle();
    bit e0, e1, g0, g1, rv0, rv1;
    logic [34:0] f;
    e0 = req0_valid && !out_v[0];
    e1 = req1_valid && !out_v[1];
    g0 = !rst && e0 && (!e1 || !last_grant1);
    g1 = !rst && e1 && (!e0 || last_grant1);
    check("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    check("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, last_op});
    check("alu_a", alu_a, last_a);
    check("alu_b", alu_b, last_b);
    rv0 = out_v[0] && (cyc >= acc_cyc[0] + 2);
    rv1 = out_v[1] && (cyc >= acc_cyc[1] + 2);
    check("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, rv0});
    check("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, rv1});
    if (rv0) begin
      f = exp_q0[0];
      check("rsp0_c", rsp0_c, f[31:0]);
      check("rsp0_flags", {29'd0, rsp0_err, rsp0_of, rsp0_zf}, {29'd0, f[34:32]});
    end
    if (rv1) begin
      f = exp_q1[0];
      check("rsp1_c", rsp1_c, f[31:0]);
      check("rsp1_flags", {29'd0, rsp1_err, rsp1_of, rsp1_zf}, {29'd0, f[34:32]});
    end
    if (rst) begin
      model_reset();
    end else begin
      if (rv0 && rsp0_ready) begin void'(exp_q0.pop_front()); out_v[0] = 0; end
      if (rv1 && rsp1_ready) begin void'(exp_q1.pop_front()); out_v[1] = 0; end
      if (g0) begin
        exp_q0.push_back(ref_rsp(req0_op, req0_a, req0_b));
        out_v[0] = 1; acc_cyc[0] = cyc;
        last_op = req0_op; last_a = req0_a; last_b = req0_b;
        last_grant1 = 1;
      end else if (g1) begin
        exp_q1.push_back(ref_rsp(req1_op, req1_a, req1_b));
        out_v[1] = 1; acc_cyc[1] = cyc;
        last_op = req1_op; last_a = req1_a; last_b = req1_b;
        last_grant1 = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  logic        d_rst = 1'b1;
  logic        d_v0 = 1'b0, d_v1 = 1'b0, d_r0 = 1'b0, d_r1 = 1'b0;
  logic [2:0]  d_op0 = 3'd0, d_op1 = 3'd0;
  logic [31:0] d_a0 = 32'd0, d_b0 = 32'd0, d_a1 = 32'd0, d_b1 = 32'd0;

  // One clock: apply staged inputs just after the rising edge, check at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rst = d_rst;
    req0_valid = d_v0; req0_op = d_op0; req0_a = d_a0; req0_b = d_b0;
    req1_valid = d_v1; req1_op = d_op1; req1_a = d_a1; req1_b = d_b1;
    rsp0_ready = d_r0; rsp1_ready = d_r1;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic do_reset();
    d_rst = 1'b1;
    tick();
    d_rst = 1'b0;
  endtask

  function automatic logic [2:0] rand_op();
    logic [2:0] ops [8];
    ops = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b010, 3'b111};
    return ops[$urandom_range(0, 7)];
  endfunction

  initial begin
    model_reset();

    // Reset held 2 cycles with req0 presenting ADD 0x7FFFFFFF + 1
    d_rst = 1'b1; d_v0 = 1'b1; d_op0 = 3'b100; d_a0 = 32'h7FFFFFFF; d_b0 = 32'd1;
    d_r0 = 1'b1; d_r1 = 1'b1;
    tick();
    tick();
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    d_rst = 1'b0;
    tick();
    check("first_acc_req0", {31'd0, req0_ready}, 32'd1);
    d_v0 = 1'b0;
    tick();
    tick();
    check("add_valid", {31'd0, rsp0_valid}, 32'd1);
    check("add_c", rsp0_c, 32'h80000000);
    check("add_of_err", {30'd0, rsp0_of, rsp0_err}, 32'd2);

    // Contention: SUB 5-5 on req0, OR 0xF0|0x0F on req1, both continuous
    do_reset();
    d_v0 = 1'b1; d_op0 = 3'b110; d_a0 = 32'd5; d_b0 = 32'd5;
    d_v1 = 1'b1; d_op1 = 3'b001; d_a1 = 32'hF0; d_b1 = 32'h0F;
    tick();
    check("cont_first_req0", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    check("cont_second_req1", {30'd0, req1_ready, req0_ready}, 32'd2);
    tick();
    check("cont_rsp0_c", rsp0_c, 32'd0);
    check("cont_rsp0_zf", {31'd0, rsp0_zf}, 32'd1);
    tick();
    check("cont_rsp1_c", rsp1_c, 32'hFF);
    repeat (10) tick();

    // Backpressure on rsp0 while req1 keeps being served
    d_r0 = 1'b0;
    repeat (14) begin
      d_op1 = rand_op(); d_a1 = $urandom; d_b1 = $urandom;
      tick();
    end
    check("bp_rsp0_held", {31'd0, rsp0_valid}, 32'd1);
    check("bp_req0_blocked", {31'd0, req0_ready}, 32'd0);
    d_r0 = 1'b1;
    repeat (6) tick();
    d_v0 = 1'b0; d_v1 = 1'b0;
    repeat (4) tick();

    // Illegal op 111 on req1
    do_reset();
    d_v1 = 1'b1; d_op1 = 3'b111; d_a1 = 32'h1234; d_b1 = 32'h5678;
    tick();
    check("ill_accept", {31'd0, req1_ready}, 32'd1);
    d_v1 = 1'b0;
    tick();
    tick();
    check("ill_err", {28'd0, rsp1_valid, rsp1_err, rsp1_of, rsp1_zf}, 32'hC);
    check("ill_c", rsp1_c, 32'd0);
    tick();

    // Reset during the EXEC cycle of a req0 operation
    do_reset();
    d_v0 = 1'b1; d_op0 = 3'b100; d_a0 = 32'd3; d_b0 = 32'd4;
    tick();
    check("rexec_accept", {31'd0, req0_ready}, 32'd1);
    d_v0 = 1'b0;
    do_reset();
    repeat (5) begin
      tick();
      check("rexec_no_rsp", {31'd0, rsp0_valid}, 32'd0);
    end
    d_v0 = 1'b1;
    tick();
    check("rexec_busy_clear", {31'd0, req0_ready}, 32'd1);
    d_v0 = 1'b0;
    repeat (4) tick();

    // Randomized traffic with occasional reset
    repeat (600) begin
      d_rst = ($urandom_range(0, 63) == 0);
      d_v0 = $urandom_range(0, 1); d_op0 = rand_op(); d_a0 = $urandom; d_b0 = $urandom;
      d_v1 = $urandom_range(0, 1); d_op1 = rand_op(); d_a1 = $urandom; d_b1 = $urandom;
      if ($urandom_range(0, 3) == 0) begin d_a0 = d_b0; d_a1 = 32'h7FFFFFFF; end
      d_r0 = ($urandom_range(0, 3) != 0);
      d_r1 = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Arbitrates a single shared 32-bit ALU between two requesters (e.g. main execute path and address/branch helper) using valid/ready handshakes and round-robin priority. Registers the granted operands into the ALU's input port, captures the ALU's combinational result, and returns it on the owning requester's response port. Each requester may have at most one operation outstanding.

## Interface
- No parameters; data width fixed at 32, requester count fixed at 2.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester i presents an operation
- req0_ready / req1_ready  out  1  requester i's operation is accepted this cycle
- req0_op / req1_op  in  3  ALU control code
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- rsp0_valid / rsp1_valid  out  1  result available for requester i
- rsp0_ready / rsp1_ready  in  1  requester i consumes result
- rsp0_c / rsp1_c  out  32  result word
- rsp0_zf, rsp0_of / rsp1_zf, rsp1_of  out  1  zero / overflow flags
- rsp0_err / rsp1_err  out  1  operation code was illegal
- alu_ctrl  out  3  to ALU control input (registered)
- alu_a, alu_b  out  32  to ALU operands (registered)
- alu_c  in  32  ALU result (combinational from alu_*)
- alu_zf, alu_of  in  1  ALU flags

## Operation
- Legal op codes: 000 AND, 001 OR, 011 unsigned SLT, 100 ADD (of valid), 101 ADDU, 110 SUB (zf, of valid). 010 and 111 illegal.
- Per requester: busy_i flag, set on request accept, cleared on response handshake (rsp_i_valid & rsp_i_ready).
- Eligible_i = req_i_valid & ~busy_i. Stage-1 slot accepts one request per cycle.
- Arbitration: if both eligible, grant goes to requester named by priority pointer `rr`; `rr` then points to the other requester. Single eligible requester is granted regardless of `rr`; `rr` flips to the non-granted one. No grant: `rr` unchanged.
- req_i_ready = granted_i (combinational from valid, busy, rr); at most one ready high per cycle.
- Stage 1 (EXEC): on grant, alu_ctrl/alu_a/alu_b load op/a/b, exec_valid=1, exec_id=i. Otherwise exec_valid=0; alu_* hold last values.
- Stage 2 (RESP): when exec_valid, buffer of exec_id loads alu_c/alu_zf/alu_of and sets rsp_valid. Illegal op: buffer loads c=0, zf=0, of=0, err=1 (ALU output ignored). Legal: err=0.
- Response buffer holds contents, rsp_valid stays high until handshake; then rsp_valid=0 and busy_i cleared on same edge.
- Flags are passed through unmasked; consumers interpret zf/of only for ops defining them.

## Timing
- Reset values: all ready/valid/err/zf/of outputs 0, rsp_c 0, alu_ctrl 000, alu_a/alu_b 0, busy 0, rr=0 (requester 0 first), exec_valid 0.
- Latency: accept at cycle t, ALU evaluates during t+1, rsp_i_valid high from t+2.
- Ready depends only on registered busy, never on rsp_ready same cycle: same requester issue interval minimum 3 cycles (accept t, handshake t+2, ready again t+3).
- Two requesters may alternate: accepts on consecutive cycles allowed.
- Response backpressure: rsp_valid held indefinitely with stable data; busy blocks new accepts from that requester only.
- Reset asserted mid-operation: in-flight op and buffered results discarded, all state to reset values next edge; no response emitted afterwards.
- req_valid dropped before grant: no effect; no state change.

## Test plan
- Reset: rst high 2 cycles with req0_valid=1 -> req0_ready=0, rsp*_valid=0, alu_* zero; after release, req0 accepted first cycle.
- Single ADD: req0 op=100, a=0x7FFFFFFF, b=1 at t -> rsp0_valid at t+2, c=0x80000000, of=1, err=0.
- Contention: both valid with SUB 5-5 (req0) and OR 0xF0|0x0F (req1) continuously -> req0 granted first, req1 next cycle; rsp0 c=0 zf=1, rsp1 c=0xFF; grants alternate thereafter.
- Backpressure: rsp0_ready=0 for 10 cycles after result -> rsp0 holds value, req0_ready stays 0, req1 still served; handshake then req0_ready returns next cycle.
- Illegal op 111 on req1 -> rsp1 c=0, zf=0, of=0, err=1 at t+2.
- Reset during EXEC cycle after accepting req0 -> rsp0_valid never asserts, busy0 cleared.
